// File: rtl/axi_dma_engine_rdata_realign_if.sv
// axi_dma_engine_rdata_realign_if: AXI-stream beat bundle for the MM2S read-data realigner
interface axi_dma_engine_rdata_realign_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic [4:0]              user;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (output data, keep, user, last, valid, input ready);
    modport slave  (input data, keep, user, last, valid, output ready);
endinterface

// File: rtl/axi_dma_engine_rdata_realign.sv
// axi_dma_engine_rdata_realign: MM2S read-data realigner that packs unaligned bursts from byte 0
// Define AXI_DMA_RDATA_REALIGN_OUT_REG_EN to register m_mm2s_axis through a 2-entry skid buffer.
module axi_dma_engine_rdata_realign #(
    parameter int  DATA_WIDTH = 32,
    parameter real SIM_DELAY  = 1.0
) (
    input  logic                           axis_aclk,
    input  logic                           axis_aresetn,
    axi_dma_engine_rdata_realign_if.slave  s_mm2s_axis,
    axi_dma_engine_rdata_realign_if.master m_mm2s_axis
);
    localparam int N  = DATA_WIDTH / 8;
    localparam int L  = $clog2(N);
    localparam int BW = DATA_WIDTH - 8;
    localparam logic [L+3:0] DW_BITS = (L+4)'(DATA_WIDTH);
    localparam logic [L:0]   N_BYTES = (L+1)'(N);

    typedef enum logic [1:0] {FIRST, MID, FLUSH} state_t;

    state_t                state, state_nx;
    logic                  first_r;
    logic [L-1:0]          off_r, off;
    logic [BW-1:0]         buf_data, buf_data_nx;
    logic [N-2:0]          buf_keep, buf_keep_nx;
    logic [DATA_WIDTH-1:0] sh_data, mix_data, c_data;
    logic [N-1:0]          sh_keep, mix_keep, c_keep;
    logic                  c_last, c_valid, c_ready, s_rdy, s_hs;

    // The offset is taken live on the first beat and from off_r for the rest of the packet
    assign off      = (state == FIRST && first_r) ? s_mm2s_axis.user[L-1:0] : off_r;
    assign sh_data  = s_mm2s_axis.data >> {off, 3'b000};
    assign sh_keep  = s_mm2s_axis.keep >> off;
    assign mix_data = {8'h00, buf_data} | (s_mm2s_axis.data << (DW_BITS - {1'b0, off, 3'b000}));
    assign mix_keep = {1'b0, buf_keep} | (s_mm2s_axis.keep << (N_BYTES - {1'b0, off}));
    assign s_hs     = s_mm2s_axis.valid && s_rdy;
    assign s_mm2s_axis.ready = s_rdy;
    assign m_mm2s_axis.user  = '0;

    always_comb begin
        state_nx    = state;
        buf_data_nx = buf_data;
        buf_keep_nx = buf_keep;
        c_data      = s_mm2s_axis.data;
        c_keep      = s_mm2s_axis.keep;
        c_last      = s_mm2s_axis.last;
        c_valid     = s_mm2s_axis.valid;
        s_rdy       = c_ready;
        if (state == FIRST) begin
            if (s_mm2s_axis.last) begin
                c_data = sh_data;
                c_keep = sh_keep;
            end else if (off != '0) begin
                c_valid = 1'b0;
                s_rdy   = 1'b1;
                if (s_mm2s_axis.valid) begin
                    buf_data_nx = sh_data[BW-1:0];
                    buf_keep_nx = sh_keep[N-2:0];
                    state_nx    = MID;
                end
            end
        end else if (state == MID) begin
            c_data = mix_data;
            c_keep = mix_keep;
            c_last = s_mm2s_axis.last && sh_keep == '0;
            if (s_mm2s_axis.valid && c_ready) begin
                buf_data_nx = c_last ? '0 : sh_data[BW-1:0];
                buf_keep_nx = c_last ? '0 : sh_keep[N-2:0];
                state_nx    = c_last ? FIRST : s_mm2s_axis.last ? FLUSH : MID;
            end
        end else begin
            c_data  = {8'h00, buf_data};
            c_keep  = {1'b0, buf_keep};
            c_last  = 1'b1;
            c_valid = 1'b1;
            s_rdy   = 1'b0;
            if (c_ready) begin
                buf_data_nx = '0;
                buf_keep_nx = '0;
                state_nx    = FIRST;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state    <= FIRST;
            first_r  <= 1'b1;
            off_r    <= '0;
            buf_data <= '0;
            buf_keep <= '0;
        end else begin
            state    <= state_nx;
            first_r  <= s_hs ? s_mm2s_axis.last : first_r;
            off_r    <= (s_hs && state == FIRST && first_r) ? off : off_r;
            buf_data <= buf_data_nx;
            buf_keep <= buf_keep_nx;
        end
    end

`ifdef AXI_DMA_RDATA_REALIGN_OUT_REG_EN
    localparam int SKW = DATA_WIDTH + N + 1;

    logic [SKW-1:0] sk0, sk1, c_word;
    logic [1:0]     sk_cnt;
    logic           push, pop;

    assign c_word  = {c_last, c_keep, c_data};
    assign c_ready = sk_cnt != 2'd2;
    assign push    = c_valid && c_ready;
    assign pop     = sk_cnt != 2'd0 && m_mm2s_axis.ready;
    assign {m_mm2s_axis.last, m_mm2s_axis.keep, m_mm2s_axis.data} = sk0;
    assign m_mm2s_axis.valid = sk_cnt != 2'd0;

    // sk0 is always the head; sk1 only fills while the head is stalled
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            sk0    <= '0;
            sk1    <= '0;
            sk_cnt <= '0;
        end else begin
            if (pop)
                sk0 <= sk_cnt[1] ? sk1 : c_word;
            else if (push && sk_cnt == 2'd0)
                sk0 <= c_word;
            if (push && !pop && sk_cnt == 2'd1)
                sk1 <= c_word;
            sk_cnt <= sk_cnt + 2'(push) - 2'(pop);
        end
    end
`else
    assign c_ready           = m_mm2s_axis.ready;
    assign m_mm2s_axis.data  = c_data;
    assign m_mm2s_axis.keep  = c_keep;
    assign m_mm2s_axis.last  = c_last;
    assign m_mm2s_axis.valid = c_valid;
`endif
endmodule

// File: tb/tb_axi_dma_engine_rdata_realign.sv
// tb_axi_dma_engine_rdata_realign: scoreboard bench with a byte-stream packing model
module tb_axi_dma_engine_rdata_realign;
    localparam int DW = 32;
    localparam int N  = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } beat_t;

`ifdef AXI_DMA_RDATA_REALIGN_OUT_REG_EN
    localparam logic LAT0 = 1'b0;
`else
    localparam logic LAT0 = 1'b1;
`endif

    logic axis_aclk = 1'b0;
    logic axis_aresetn = 1'b0;

    axi_dma_engine_rdata_realign_if #(.DATA_WIDTH(DW)) s_if ();
    axi_dma_engine_rdata_realign_if #(.DATA_WIDTH(DW)) m_if ();

    axi_dma_engine_rdata_realign #(.DATA_WIDTH(DW)) dut (
        .axis_aclk   (axis_aclk),
        .axis_aresetn(axis_aresetn),
        .s_mm2s_axis (s_if),
        .m_mm2s_axis (m_if)
    );

    always #5 axis_aclk = ~axis_aclk;

    beat_t         exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            rdy_mode = 0;
    int            stalls = 0;
    logic          tog = 1'b0;
    logic [7:0]    pb[64];
    logic [DW-1:0] in_d[64];
    logic [N-1:0]  in_k[64];
    int            n_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // 0: always ready, 1: random, 2: alternating, 3: held low
    always @(posedge axis_aclk) begin
        #2;
        tog = ~tog;
        m_if.ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) :
                     rdy_mode == 2 ? tog : 1'b0;
    end

    logic          hold_v = 1'b0;
    logic [DW+N:0] hold_w;
    always @(negedge axis_aclk) begin
        beat_t         e;
        logic [DW-1:0] mask;
        if (!axis_aresetn) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                chk("stall_valid", 64'(m_if.valid), 64'd1);
                chk("stall_hold", 64'({m_if.last, m_if.keep, m_if.data}), 64'(hold_w));
            end
            hold_v = m_if.valid && !m_if.ready;
            hold_w = {m_if.last, m_if.keep, m_if.data};
            if (m_if.valid && m_if.ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h keep %0h with no beat expected", m_if.data, m_if.keep);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < N; i++) mask[i*8+:8] = {8{e.keep[i]}};
                    chk("out_data", 64'(m_if.data & mask), 64'(e.data));
                    chk("out_keep", 64'(m_if.keep), 64'(e.keep));
                    chk("out_last", 64'(m_if.last), 64'(e.last));
                end
            end
        end
    end

    // Lay pb[0..t-1] out on the bus starting at lane off; expected output is the same bytes packed from lane 0
    task automatic build_pkt(input int off, input int t, input bit expect_out);
        beat_t e;
        int    nb;
        n_in = (off + t + N - 1) / N;
        for (int b = 0; b < n_in; b++) begin
            in_d[b] = DW'($urandom);
            in_k[b] = '0;
        end
        for (int i = 0; i < t; i++) begin
            int p = off + i;
            in_d[p/N][(p%N)*8+:8] = pb[i];
            in_k[p/N][p%N] = 1'b1;
        end
        nb = (t + N - 1) / N;
        for (int b = 0; b < nb && expect_out; b++) begin
            e.data = '0;
            e.keep = '0;
            e.last = b == nb - 1;
            for (int j = 0; j < N; j++)
                if (b * N + j < t) begin
                    e.data[j*8+:8] = pb[b*N+j];
                    e.keep[j] = 1'b1;
                end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_hs();
        int n = 0;
        forever begin
            @(negedge axis_aclk);
            if (s_if.ready) break;
            stalls++;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL hs_timeout: s_ready low for %0d cycles, want a handshake", n);
                break;
            end
        end
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic drive_pkt(input int off, input bit gaps);
        logic [4:0] u;
        for (int b = 0; b < n_in; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_if.valid = 1'b0;
                @(posedge axis_aclk);
                #1;
            end
            u = 5'($urandom);
            if (b == 0) u = (u & ~5'(N - 1)) | 5'(off);
            s_if.valid = 1'b1;
            s_if.data  = in_d[b];
            s_if.keep  = in_k[b];
            s_if.last  = b == n_in - 1;
            s_if.user  = u;
            wait_hs();
        end
        s_if.valid = 1'b0;
    endtask

    task automatic seq_bytes(input int t);
        for (int i = 0; i < t; i++) pb[i] = 8'(8'hD2 + i);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axis_aclk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge axis_aclk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int off, t;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.keep  = '0;
        s_if.user  = '0;
        s_if.last  = 1'b0;
        idle(3);
        @(negedge axis_aclk);
        chk("rst_m_valid", 64'(m_if.valid), 64'd0);
`ifdef AXI_DMA_RDATA_REALIGN_OUT_REG_EN
        chk("rst_m_word", 64'({m_if.last, m_if.keep, m_if.data}), 64'd0);
`endif
        @(posedge axis_aclk);
        #1;
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        chk("idle_m_valid", 64'(m_if.valid), 64'd0);
        chk("idle_s_ready", 64'(s_if.ready), 64'd1);
        idle(1);

        // off=2, full last beat: two outputs, flush cycle blocks input
        seq_bytes(6);
        build_pkt(2, 6, 1);
        drive_pkt(2, 0);
        @(negedge axis_aclk);
        chk("flush_s_ready", 64'(s_if.ready), 64'd0);
        chk("flush_m_valid", 64'(m_if.valid), 64'd1);
        idle(4);
        drain();

        // off=2, short last beat: one output, no flush
        seq_bytes(4);
        build_pkt(2, 4, 1);
        drive_pkt(2, 0);
        @(negedge axis_aclk);
        chk("noflush_s_ready", 64'(s_if.ready), 64'd1);
        idle(4);
        drain();

        // off=3 single beat, output in the same cycle without the skid register
        seq_bytes(1);
        build_pkt(3, 1, 1);
        s_if.valid = 1'b1;
        s_if.data  = in_d[0];
        s_if.keep  = in_k[0];
        s_if.last  = 1'b1;
        s_if.user  = 5'd3;
        @(negedge axis_aclk);
        chk("single_same_cycle_valid", 64'(m_if.valid), 64'(LAT0));
        chk("single_s_ready", 64'(s_if.ready), 64'd1);
        @(posedge axis_aclk);
        #1;
        s_if.valid = 1'b0;
        idle(4);
        drain();

        // off=0 pass-through under alternating ready
        rdy_mode = 2;
        idle(2);
        for (int i = 0; i < 12; i++) pb[i] = 8'($urandom);
        build_pkt(0, 12, 1);
        drive_pkt(0, 0);
        idle(2);
        drain();

        // Reset while MID holds carried bytes
        rdy_mode = 3;
        idle(2);
        for (int i = 0; i < 8; i++) pb[i] = 8'($urandom);
        build_pkt(2, 8, 0);
        s_if.valid = 1'b1;
        s_if.data  = in_d[0];
        s_if.keep  = in_k[0];
        s_if.last  = 1'b0;
        s_if.user  = 5'd2;
        wait_hs();
        s_if.data = in_d[1];
        s_if.keep = in_k[1];
        s_if.user = 5'($urandom);
        idle(2);
        @(negedge axis_aclk);
        chk("mid_m_valid", 64'(m_if.valid), 64'd1);
        @(posedge axis_aclk);
        #1;
        s_if.user    = 5'd2;
        axis_aresetn = 1'b0;
        #1;
        chk("async_rst_m_valid", 64'(m_if.valid), 64'd0);
        @(posedge axis_aclk);
        #1;
        s_if.valid = 1'b0;
        idle(1);
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        chk("post_rst_m_valid", 64'(m_if.valid), 64'd0);
        rdy_mode = 1;
        idle(1);
        for (int i = 0; i < 9; i++) pb[i] = 8'($urandom);
        build_pkt(1, 9, 1);
        drive_pkt(1, 1);
        rdy_mode = 0;
        drain();

        // Back-to-back aligned packets must never see s_ready drop
        idle(3);
        stalls = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) pb[i] = 8'($urandom);
            build_pkt(0, 16, 1);
            drive_pkt(0, 0);
        end
        chk("full_rate_stalls", 64'(stalls), 64'd0);
        drain();

        // Randomised packets, offsets, lengths, gaps and backpressure
        for (int p = 0; p < 150; p++) begin
            rdy_mode = $urandom_range(0, 2);
            off = $urandom_range(0, N - 1);
            t   = $urandom_range(1, 24);
            for (int i = 0; i < t; i++) pb[i] = 8'($urandom);
            build_pkt(off, t, 1);
            drive_pkt(off, 1);
        end
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
